// File: rtl/pcm_out_stage_pkg.sv
// Shared PCM constants and the accumulator width define for the PCM output stage.
// DATA_WIDTH may be overridden on the command line; it defaults to 32.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pcm_out_stage_pkg;
  localparam int unsigned PCM_WIDTH = 16;
  localparam logic [PCM_WIDTH-1:0] PCM_MAX = 16'h7FFF;
  localparam logic [PCM_WIDTH-1:0] PCM_MIN = 16'h8000;

  typedef logic [PCM_WIDTH-1:0] pcm_t;
endpackage

// File: rtl/pcm_out_stage_fifo.sv
// Power-of-two FIFO with a registered head output and an occupancy count.
module pcm_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_ptr_n;
  logic [AW:0]      r_count;
  logic [AW:0]      w_rem;
  logic [AW:0]      w_count_n;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_n;
  logic             r_valid;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = r_valid && i_pop;
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  // The head register is preloaded with whichever entry will sit at the read
  // pointer after this edge; a push into an emptied FIFO bypasses the array.
  always_comb begin
    w_rd_ptr_n = r_rd_ptr + AW'(w_pop);
    w_rem      = r_count - (AW+1)'(w_pop);
    w_count_n  = w_rem + (AW+1)'(w_push);
    w_head_n   = r_head;
    if (w_rem != '0)
      w_head_n = r_mem[w_rd_ptr_n];
    else if (w_push)
      w_head_n = i_din;
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_head   <= w_head_n;
      r_valid  <= (w_count_n != '0);
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;
endmodule

// File: rtl/pcm_out_stage.sv
// Rounds finished MAC sums to saturated 16-bit PCM and buffers them toward the serializer.
// Optional saturation event counter (sat_cnt port) is built when PCM_SAT_CNT_EN is defined.
module pcm_out_stage
  import pcm_out_stage_pkg::*;
#(
  parameter int unsigned SHIFT = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [`DATA_WIDTH-1:0] acc_in,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  output logic [PCM_WIDTH-1:0]   pcm_data,
  output logic                   pcm_valid,
  input  logic                   pcm_ready,
  output logic                   ovf,
  input  logic                   clr_ovf
`ifdef PCM_SAT_CNT_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic signed [DW:0] RND  = (DW+1)'(1) << (SHIFT - 1);
  localparam logic signed [DW:0] SMAX = (DW+1)'(32767);
  localparam logic signed [DW:0] SMIN = -SMAX - 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic signed [DW:0] w_sum;
  logic signed [DW:0] w_shr;
  logic               w_hi;
  logic               w_lo;
  pcm_t               w_pcm;
  pcm_t               r_s_data;
  logic               r_s_valid;
  logic [CW-1:0]      w_count;
  logic               w_accept;
  logic               w_drop;
  logic               w_pop;
  logic               r_ovf;

  // Sign-extend by one bit first so adding the rounding constant cannot wrap.
  assign w_sum = $signed({acc_in[DW-1], acc_in}) + RND;
  assign w_shr = w_sum >>> SHIFT;
  assign w_hi  = (w_shr > SMAX);
  assign w_lo  = (w_shr < SMIN);
  assign w_pcm = w_hi ? PCM_MAX : (w_lo ? PCM_MIN : w_shr[PCM_WIDTH-1:0]);

  // Reserving a slot for the stage register means it never has to stall.
  assign acc_ready = (({1'b0, w_count} + {{CW{1'b0}}, r_s_valid}) < DEPTH_C);
  assign w_accept  = acc_valid && acc_ready;
  assign w_drop    = acc_valid && !acc_ready;
  assign w_pop     = pcm_valid && pcm_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s_data  <= '0;
      r_s_valid <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept)
        r_s_data <= w_pcm;
      r_s_valid <= w_accept;
      if (clr_ovf)
        r_ovf <= 1'b0;
      else if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

`ifdef PCM_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_sat_cnt <= '0;
    else if (clr_ovf)
      r_sat_cnt <= '0;
    else if (w_accept && (w_hi || w_lo) && (r_sat_cnt != '1))
      r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign sat_cnt = r_sat_cnt;
`endif

  pcm_fifo #(
    .WIDTH (PCM_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_push  (r_s_valid),
    .i_din   (r_s_data),
    .i_pop   (w_pop),
    .o_head  (pcm_data),
    .o_valid (pcm_valid),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_pcm_out_stage.sv
// Scoreboard bench for pcm_out_stage: directed accumulator vectors with hand-computed PCM results.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_pcm_out_stage;
  import pcm_out_stage_pkg::*;

  localparam int unsigned DW = `DATA_WIDTH;

  logic          clock;
  logic          resetn;
  logic [DW-1:0] acc_in;
  logic          acc_valid;
  logic          acc_ready;
  logic [15:0]   pcm_data;
  logic          pcm_valid;
  logic          pcm_ready;
  logic          ovf;
  logic          clr_ovf;
`ifdef PCM_SAT_CNT_EN
  logic [15:0]   sat_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  pcm_out_stage #(
    .SHIFT (8),
    .DEPTH (4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
`ifdef PCM_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_acc(input logic [DW-1:0] v, input logic [15:0] e);
    int unsigned w = 0;
    while (!acc_ready && w < 50) begin
      tick();
      w++;
    end
    if (!acc_ready) begin
      check("acc_ready_wait", {31'd0, acc_ready}, 32'd1);
    end else begin
      acc_in    = v;
      acc_valid = 1'b1;
      exp_q.push_back(e);
      tick();
      acc_valid = 1'b0;
    end
  endtask

  task automatic drop_acc(input logic [DW-1:0] v);
    acc_in    = v;
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    check("drain_left", exp_q.size(), 0);
    tick();
  endtask

  always @(negedge clock) begin : monitor
    logic [15:0] e;
    if (resetn && pcm_valid && pcm_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pcm_out: got 0x%0h, want no output", pcm_data);
      end else begin
        e = exp_q.pop_front();
        check("pcm_out", {16'd0, pcm_data}, {16'd0, e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    acc_in    = '0;
    acc_valid = 1'b0;
    pcm_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (3) tick();
    check("rst_pcm_valid", {31'd0, pcm_valid}, 0);
    check("rst_pcm_data", {16'd0, pcm_data}, 0);
    check("rst_acc_ready", {31'd0, acc_ready}, 1);
    check("rst_ovf", {31'd0, ovf}, 0);
`ifdef PCM_SAT_CNT_EN
    check("rst_sat_cnt", {16'd0, sat_cnt}, 0);
`endif
    resetn = 1'b1;
    tick();

    // Rounding, including the negative half-way points.
    push_acc(32'h0001_2380, 16'h0124);
    push_acc(32'h0001_237F, 16'h0123);
    push_acc(32'hFFFF_FF80, 16'h0000);
    push_acc(32'hFFFF_FF7F, 16'hFFFF);
    push_acc(32'h007F_FF7F, 16'h7FFF);
    drain();

    // Saturation at both rails.
    push_acc(32'h0080_0000, 16'h7FFF);
    push_acc(32'hFF80_0000, 16'h8000);
    push_acc(32'hFF7F_FF00, 16'h8000);
`ifdef PCM_SAT_CNT_EN
    check("sat_cnt_2", {16'd0, sat_cnt}, 2);
`endif
    push_acc(32'h7FFF_FFFF, 16'h7FFF);
`ifdef PCM_SAT_CNT_EN
    check("sat_cnt_3", {16'd0, sat_cnt}, 3);
`endif
    drain();

    // Fill with the consumer stalled, then drop one sample.
    pcm_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      push_acc(DW'(i) << 8, 16'(i));
    check("fill_acc_ready", {31'd0, acc_ready}, 0);
    drop_acc(32'h0000_0500);
    check("fill_ovf", {31'd0, ovf}, 1);
    check("fill_head_valid", {31'd0, pcm_valid}, 1);
    tick();
    check("fill_head_stable", {16'd0, pcm_data}, 1);
    pcm_ready = 1'b1;
    drain();
    repeat (3) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", {31'd0, ovf}, 0);
`ifdef PCM_SAT_CNT_EN
    check("clr_sat_cnt", {16'd0, sat_cnt}, 0);
`endif

    // Full buffer, then concurrent streaming in and out.
    pcm_ready = 1'b0;
    for (int i = 16; i < 20; i++)
      push_acc(DW'(i) << 8, 16'(i));
    pcm_ready = 1'b1;
    for (int i = 20; i < 28; i++)
      push_acc(DW'(i) << 8, 16'(i));
    check("stream_ovf", {31'd0, ovf}, 0);
    drain();

    // Asynchronous reset with samples buffered.
    pcm_ready = 1'b0;
    for (int i = 33; i < 37; i++)
      push_acc(DW'(i) << 8, 16'(i));
    drop_acc(32'h0000_2500);
    check("pre_rst_ovf", {31'd0, ovf}, 1);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_pcm_valid", {31'd0, pcm_valid}, 0);
    check("mid_rst_acc_ready", {31'd0, acc_ready}, 1);
    check("mid_rst_ovf", {31'd0, ovf}, 0);
    check("mid_rst_pcm_data", {16'd0, pcm_data}, 0);
    tick();
    resetn    = 1'b1;
    pcm_ready = 1'b1;
    acc_in    = 32'h0012_3400;
    acc_valid = 1'b1;
    exp_q.push_back(16'h1234);
    tick();
    acc_valid = 1'b0;
    check("lat_edge_n", {31'd0, pcm_valid}, 0);
    tick();
    check("lat_edge_n1_valid", {31'd0, pcm_valid}, 1);
    check("lat_edge_n1_data", {16'd0, pcm_data}, 32'h1234);
    drain();

    // Clear coinciding with a drop wins.
    pcm_ready = 1'b0;
    for (int i = 49; i < 53; i++)
      push_acc(DW'(i) << 8, 16'(i));
    drop_acc(32'h0000_6000);
    check("coinc_pre_ovf", {31'd0, ovf}, 1);
    acc_in    = 32'h0000_6100;
    acc_valid = 1'b1;
    clr_ovf   = 1'b1;
    tick();
    acc_valid = 1'b0;
    clr_ovf   = 1'b0;
    check("coinc_ovf", {31'd0, ovf}, 0);
    pcm_ready = 1'b1;
    drain();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
